// File: rtl/mod_down_timer.sv
// ---------------------------------------------------------------------------
// mod_down_timer
//
// Programmable modulus down-counter/timer. A start strobe loads a start value,
// the count then decrements on every enabled clock. When the count expires at
// zero a one-cycle done pulse is produced on the following cycle, after which
// the timer either stops (one-shot) or reloads the latched start value
// (auto-reload). A start value N therefore gives N+1 enabled cycles per expiry.
//
// Optional feature macro: MOD_DOWN_TIMER_CLAMP_EN
//   defined   : start values above FINAL_VALUE are loaded as FINAL_VALUE
//   undefined : start values are loaded unmodified (any W-bit value)
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-high reset
//   enable       in   1  count qualifier for decrement/expiry
//   start        in   1  single-cycle load strobe (works in any state)
//   start_value  in   W  value loaded on start
//   auto_reload  in   1  sampled at start: 1 = periodic, 0 = one-shot
//   abort        in   1  stop immediately without a done pulse
//   Q            out  W  current count (registered)
//   busy         out  1  high while in RUN
//   done         out  1  registered one-cycle expiry pulse
// ---------------------------------------------------------------------------
module mod_down_timer #(
    parameter int FINAL_VALUE = 13,
    localparam int W = $clog2(FINAL_VALUE + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic [W-1:0] start_value,
    input  logic         auto_reload,
    input  logic         abort,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_countNext;
    logic [W-1:0]   r_reload;
    logic [W-1:0]   w_reloadNext;
    logic           r_mode;
    logic           w_modeNext;
    logic           r_done;
    logic           w_doneNext;
    logic [W-1:0]   w_loadValue;

    // The value actually loaded on start. With clamping enabled, anything
    // above the largest legal start value is pinned to that value so the
    // period never exceeds FINAL_VALUE+1 enabled cycles.
`ifdef MOD_DOWN_TIMER_CLAMP_EN
    assign w_loadValue = (start_value > W'(FINAL_VALUE)) ? W'(FINAL_VALUE)
                                                          : start_value;
`else
    assign w_loadValue = start_value;
`endif

    // State register plus all datapath registers. Everything visible on the
    // outputs comes straight from these flops, so there is no combinational
    // path from any input to Q, busy or done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_count  <= w_countNext;
            r_reload <= w_reloadNext;
            r_mode   <= w_modeNext;
            r_done   <= w_doneNext;
        end
    end

    // Next-state and next-datapath logic. Priority is abort, then start,
    // then expiry, then plain decrement. Start is deliberately independent
    // of enable so a load always takes effect on the strobe edge. Expiry is
    // detected when an enabled edge finds the count already at zero, which
    // is what gives N+1 enabled cycles per period and avoids any underflow.
    always_comb begin
        w_stateNext  = r_state;
        w_countNext  = r_count;
        w_reloadNext = r_reload;
        w_modeNext   = r_mode;
        w_doneNext   = 1'b0;

        if (abort) begin
            w_stateNext = IDLE;
            w_countNext = '0;
        end else if (start) begin
            w_stateNext  = RUN;
            w_countNext  = w_loadValue;
            w_reloadNext = w_loadValue;
            w_modeNext   = auto_reload;
        end else if (r_state == RUN && enable) begin
            if (r_count == '0) begin
                w_doneNext = 1'b1;
                if (r_mode) begin
                    w_countNext = r_reload;
                end else begin
                    w_countNext = '0;
                    w_stateNext = IDLE;
                end
            end else begin
                w_countNext = r_count - W'(1);
            end
        end
    end

    assign Q    = r_count;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule

// File: tb/tb_mod_down_timer.sv
// ---------------------------------------------------------------------------
// tb_mod_down_timer
//
// Self-checking bench for mod_down_timer. A reference model advances on each
// rising edge from the inputs it sees, pushes the expected {Q, busy, done}
// onto a scoreboard queue, and the entry is popped and compared against the
// DUT shortly after the edge. Directed scenario checks with hand-derived
// constants run alongside. Honours MOD_DOWN_TIMER_CLAMP_EN like the design.
// ---------------------------------------------------------------------------
module tb_mod_down_timer;

    localparam int FINAL_VALUE = 13;
    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         start;
    logic [W-1:0] startValue;
    logic         autoReload;
    logic         abort;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    typedef struct {
        int q;
        int busy;
        int done;
    } expect_t;

    expect_t scoreboard[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int doneCount   = 0;

    int mQ      = 0;
    int mBusy   = 0;
    int mDone   = 0;
    int mReload = 0;
    int mMode   = 0;

    mod_down_timer #(
        .FINAL_VALUE(FINAL_VALUE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .start_value(startValue),
        .auto_reload(autoReload),
        .abort      (abort),
        .Q          (q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Expected load value, including the optional clamp.
    function automatic int loadOf(input int sv);
`ifdef MOD_DOWN_TIMER_CLAMP_EN
        return (sv > FINAL_VALUE) ? FINAL_VALUE : sv;
`else
        return sv;
`endif
    endfunction

    // Reference model: on each edge work out what the timer should show,
    // push it, then after the outputs settle pop the entry and compare.
    always @(posedge clk) begin
        expect_t e;
        expect_t got;
        if (reset) begin
            mQ = 0; mBusy = 0; mDone = 0; mReload = 0; mMode = 0;
        end else if (abort) begin
            mQ = 0; mBusy = 0; mDone = 0;
        end else if (start) begin
            mQ = loadOf(int'(startValue));
            mReload = mQ;
            mMode = int'(autoReload);
            mBusy = 1;
            mDone = 0;
        end else if (mBusy == 1 && enable) begin
            if (mQ == 0) begin
                mDone = 1;
                if (mMode == 1) begin
                    mQ = mReload;
                end else begin
                    mBusy = 0;
                end
            end else begin
                mQ = mQ - 1;
                mDone = 0;
            end
        end else begin
            mDone = 0;
        end
        e.q = mQ; e.busy = mBusy; e.done = mDone;
        scoreboard.push_back(e);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboardEmpty", 0, 1);
        end else begin
            got = scoreboard.pop_front();
            checkOutput("sbQ", int'(q), got.q);
            checkOutput("sbBusy", int'(busy), got.busy);
            checkOutput("sbDone", int'(done), got.done);
            if (done) doneCount++;
        end
    end

    // Drive one cycle worth of inputs, changed on the falling edge.
    task automatic applyStimulus(input logic en, input logic st, input int sv,
                                 input logic ar, input logic ab);
        @(negedge clk);
        enable     = en;
        start      = st;
        startValue = W'(sv);
        autoReload = ar;
        abort      = ab;
    endtask

    // Wait for the edge that consumes the current inputs and let it settle.
    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int edges;
        int expLoad;
        reset = 1'b1;
        enable = 1'b0; start = 1'b0; startValue = '0; autoReload = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetQ", int'(q), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        reset = 1'b0;

        // Reset mid-run with Q=5, then a start straight after release.
        applyStimulus(1'b0, 1'b1, 8, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("preResetQ", int'(q), 5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncResetQ", int'(q), 0);
        checkOutput("asyncResetBusy", int'(busy), 0);
        checkOutput("asyncResetDone", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 4, 1'b0, 1'b0);
        afterEdge();
        checkOutput("loadAfterReset", int'(q), 4);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // One-shot from 3: 3,2,1,0 then done four enabled edges after load.
        applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b0);
        doneCount = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("oneShotDone", int'(done), 1);
        checkOutput("oneShotBusy", int'(busy), 0);
        checkOutput("oneShotQ", int'(q), 0);
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("oneShotPulses", doneCount, 1);

        // Auto-reload from 2 with enable toggling: two expiries in 12 clocks.
        applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b0);
        doneCount = 0;
        for (int i = 0; i < 12; i++)
            applyStimulus((i % 2) == 0, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("reloadPulses", doneCount, 2);
        checkOutput("reloadQ", int'(q), 2);
        checkOutput("reloadBusy", int'(busy), 1);

        // Restart during run, then abort together with start.
        applyStimulus(1'b1, 1'b1, 9, 1'b0, 1'b0);
        doneCount = 0;
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("beforeRestartQ", int'(q), 6);
        applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0);
        afterEdge();
        checkOutput("restartQ", int'(q), 1);
        applyStimulus(1'b1, 1'b1, 7, 1'b1, 1'b1);
        afterEdge();
        checkOutput("abortQ", int'(q), 0);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortPulses", doneCount, 0);

        // Zero load: one-shot expires on the first enabled edge after load.
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("zeroOneShotDone", int'(done), 1);
        checkOutput("zeroOneShotBusy", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0);
        doneCount = 0;
        repeat (5) applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("zeroReloadPulses", doneCount, 5);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Over-range start value: clamped or loaded as-is.
`ifdef MOD_DOWN_TIMER_CLAMP_EN
        expLoad = 13;
`else
        expLoad = 15;
`endif
        applyStimulus(1'b0, 1'b1, 15, 1'b0, 1'b0);
        afterEdge();
        checkOutput("clampQ", int'(q), expLoad);
        edges = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
            afterEdge();
            edges++;
        end
        checkOutput("clampEdges", edges, expLoad + 1);

        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        afterEdge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
